// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-op definitions: op control encodings, bus size codes and FSM states.
// Used by ALU decode and by the MEM-stage data-bus controller.
package mem_access_ctrl_pkg;

  localparam logic [5:0] MEMOP_LB  = 6'h01;
  localparam logic [5:0] MEMOP_LBU = 6'h02;
  localparam logic [5:0] MEMOP_LH  = 6'h04;
  localparam logic [5:0] MEMOP_LHU = 6'h08;
  localparam logic [5:0] MEMOP_LW  = 6'h10;
  localparam logic [5:0] MEMOP_SB  = 6'h21;
  localparam logic [5:0] MEMOP_SH  = 6'h24;
  localparam logic [5:0] MEMOP_SW  = 6'h30;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_fmt.sv
// Combinational data formatting: store lane replication/strobes, alignment check,
// and load lane extraction with sign/zero extension.
module mem_data_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [5:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [1:0]  size,
  output logic        misaligned,
  output logic [31:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    size       = SIZE_WORD;
    wdata      = st_data;
    wstrb      = 4'b1111;
    misaligned = |st_off;
    case (st_op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: begin
        size       = SIZE_BYTE;
        wdata      = {4{st_data[7:0]}};
        wstrb      = 4'b0001 << st_off;
        misaligned = 1'b0;
      end
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
        size       = SIZE_HALF;
        wdata      = {2{st_data[15:0]}};
        wstrb      = st_off[1] ? 4'b1100 : 4'b0011;
        misaligned = st_off[0];
      end
      default: ;
    endcase
    if (!op_is_store(st_op)) wstrb = 4'b0000;
  end

  always_comb begin
    ld_byte   = ld_data[{ld_off, 3'b000} +: 8];
    ld_half   = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    ld_result = ld_data;
    case (ld_op)
      MEMOP_LB:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      MEMOP_LBU: ld_result = {24'h000000, ld_byte};
      MEMOP_LH:  ld_result = {{16{ld_half[15]}}, ld_half};
      MEMOP_LHU: ld_result = {16'h0000, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus controller: issues one load/store at a time, stalls the pipe
// while it is outstanding, and handles flush/cancel of in-flight accesses.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              memen,
  input  logic [5:0]        memop,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       writedata,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              stall_mem,
  output logic [31:0]       readdata,
  output logic              adel,
  output logic              ades,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  state_t      state, state_next;
  logic        cancel, set_cancel, clr_cancel;
  logic        capture, load_rd;
  logic [5:0]  op_q;
  logic [31:0] fmt_wdata, fmt_ld;
  logic [3:0]  fmt_wstrb;
  logic [1:0]  fmt_size;
  logic        fmt_mis;

  mem_data_fmt u_fmt (
    .st_op      (memop),
    .st_off     (addr[1:0]),
    .st_data    (writedata),
    .ld_op      (op_q),
    .ld_off     (data_addr[1:0]),
    .ld_data    (data_rdata),
    .wdata      (fmt_wdata),
    .wstrb      (fmt_wstrb),
    .size       (fmt_size),
    .misaligned (fmt_mis),
    .ld_result  (fmt_ld)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cancel     <= 1'b0;
      readdata   <= '0;
      op_q       <= '0;
      data_addr  <= '0;
      data_wr    <= 1'b0;
      data_size  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
    end else begin
      state <= state_next;
      if (clr_cancel)      cancel <= 1'b0;
      else if (set_cancel) cancel <= 1'b1;
      if (load_rd) readdata <= fmt_ld;
      if (capture) begin
        op_q       <= memop;
        data_addr  <= addr;
        data_wr    <= op_is_store(memop);
        data_size  <= fmt_size;
        data_wdata <= fmt_wdata;
        data_wstrb <= fmt_wstrb;
      end
    end
  end

  // A flush that coincides with data_ok still cancels the writeback.
  always_comb begin
    state_next = state;
    stall_mem  = 1'b0;
    data_req   = 1'b0;
    adel       = 1'b0;
    ades       = 1'b0;
    capture    = 1'b0;
    load_rd    = 1'b0;
    set_cancel = 1'b0;
    clr_cancel = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memen) begin
          if (fmt_mis) begin
            adel = !op_is_store(memop);
            ades = op_is_store(memop);
          end else if (!flush) begin
            state_next = ST_REQ;
            capture    = 1'b1;
            stall_mem  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_mem = 1'b1;
        data_req  = 1'b1;
        if (data_addr_ok) begin
          state_next = ST_WAIT;
          set_cancel = flush;
        end else if (flush) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_mem = 1'b1;
        if (data_data_ok) begin
          clr_cancel = 1'b1;
          if (cancel || flush) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DONE;
            load_rd    = !data_wr;
          end
        end else if (flush) begin
          set_cancel = 1'b1;
        end
      end
      ST_DONE: begin
        if (flush || !pipe_stall) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a hand-driven data bus.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, memen, pipe_stall, flush;
  logic [5:0]  memop;
  logic [31:0] addr, writedata, readdata, data_addr, data_wdata, data_rdata;
  logic        stall_mem, adel, ades, data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  int          errors = 0;
  int          checks = 0;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .memen(memen), .memop(memop), .addr(addr),
    .writedata(writedata), .pipe_stall(pipe_stall), .flush(flush),
    .stall_mem(stall_mem), .readdata(readdata), .adel(adel), .ades(ades),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a valid access in IDLE for one cycle; returns in the first REQ cycle.
  task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    memen = 1'b1; memop = op; addr = a; writedata = wd;
    #1;
    checkOutput({tag, "_idle_stall"}, {31'b0, stall_mem}, 32'd1);
    step();
    memen = 1'b0;
  endtask

  // Only IDLE raises stall_mem combinationally for a fresh aligned load without requesting.
  task automatic checkIdle(input string tag);
    memen = 1'b1; memop = MEMOP_LW; addr = 32'h200;
    #1;
    checkOutput({tag, "_is_idle"}, {31'b0, stall_mem}, 32'd1);
    checkOutput({tag, "_idle_noreq"}, {31'b0, data_req}, 32'd0);
    memen = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int aok_dly,
                               input int hold, input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                               input logic [1:0] exp_size, input logic exp_wr, input logic [31:0] exp_rd);
    issue(tag, op, a, wd);
    for (int i = 0; i < aok_dly; i++) begin
      checkOutput({tag, "_req_hold"}, {31'b0, data_req}, 32'd1);
      step();
    end
    checkOutput({tag, "_req"}, {31'b0, data_req}, 32'd1);
    checkOutput({tag, "_req_stall"}, {31'b0, stall_mem}, 32'd1);
    checkOutput({tag, "_addr"}, data_addr, a);
    checkOutput({tag, "_wdata"}, data_wdata, exp_wdata);
    checkOutput({tag, "_wstrb"}, {28'b0, data_wstrb}, {28'b0, exp_wstrb});
    checkOutput({tag, "_size"}, {30'b0, data_size}, {30'b0, exp_size});
    checkOutput({tag, "_wr"}, {31'b0, data_wr}, {31'b0, exp_wr});
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    checkOutput({tag, "_wait_noreq"}, {31'b0, data_req}, 32'd0);
    checkOutput({tag, "_wait_stall"}, {31'b0, stall_mem}, 32'd1);
    data_rdata = rd; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      pipe_stall = 1'b1;
      checkOutput({tag, "_done_stall"}, {31'b0, stall_mem}, 32'd0);
      checkOutput({tag, "_done_rd_held"}, readdata, exp_rd);
      step();
    end
    pipe_stall = 1'b0;
    checkOutput({tag, "_done_stall"}, {31'b0, stall_mem}, 32'd0);
    checkOutput({tag, "_readdata"}, readdata, exp_rd);
    step();
    checkIdle(tag);
  endtask

  initial begin
    resetn = 1'b0; memen = 1'b0; memop = '0; addr = '0; writedata = '0;
    pipe_stall = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    #3;
    checkOutput("rst_stall", {31'b0, stall_mem}, 32'd0);
    checkOutput("rst_req", {31'b0, data_req}, 32'd0);
    checkOutput("rst_readdata", readdata, 32'd0);
    checkOutput("rst_addr", data_addr, 32'd0);
    step(); step();
    resetn = 1'b1;

    applyStimulus("sw",  MEMOP_SW,  32'h100, 32'h12345678, 32'h0,        0, 0, 32'h12345678, 4'b1111, 2'd2, 1'b1, 32'h0);
    applyStimulus("sb",  MEMOP_SB,  32'h103, 32'h000000AB, 32'h0,        0, 0, 32'hABABABAB, 4'b1000, 2'd0, 1'b1, 32'h0);
    applyStimulus("sh",  MEMOP_SH,  32'h102, 32'h0000BEEF, 32'h0,        1, 0, 32'hBEEFBEEF, 4'b1100, 2'd1, 1'b1, 32'h0);
    applyStimulus("lb",  MEMOP_LB,  32'h101, 32'h0,        32'h000080FF, 0, 0, 32'h0,        4'b0000, 2'd0, 1'b0, 32'hFFFFFF80);
    applyStimulus("lbu", MEMOP_LBU, 32'h101, 32'h0,        32'h000080FF, 0, 0, 32'h0,        4'b0000, 2'd0, 1'b0, 32'h00000080);
    applyStimulus("lh",  MEMOP_LH,  32'h102, 32'h0,        32'h80010000, 0, 0, 32'h0,        4'b0000, 2'd1, 1'b0, 32'hFFFF8001);
    applyStimulus("lhu", MEMOP_LHU, 32'h102, 32'h0,        32'h80010000, 2, 0, 32'h0,        4'b0000, 2'd1, 1'b0, 32'h00008001);
    applyStimulus("lw",  MEMOP_LW,  32'h104, 32'h0,        32'hDEADBEEF, 3, 2, 32'h0,        4'b0000, 2'd2, 1'b0, 32'hDEADBEEF);
    applyStimulus("sw2", MEMOP_SW,  32'h108, 32'hCAFEF00D, 32'h55555555, 0, 0, 32'hCAFEF00D, 4'b1111, 2'd2, 1'b1, 32'hDEADBEEF);

    // misaligned accesses raise the error flag and never reach the bus
    memen = 1'b1; memop = MEMOP_LW; addr = 32'h102;
    #1;
    checkOutput("lw_mis_adel", {31'b0, adel}, 32'd1);
    checkOutput("lw_mis_ades", {31'b0, ades}, 32'd0);
    checkOutput("lw_mis_stall", {31'b0, stall_mem}, 32'd0);
    step();
    checkOutput("lw_mis_noreq", {31'b0, data_req}, 32'd0);
    memop = MEMOP_SH; addr = 32'h101;
    #1;
    checkOutput("sh_mis_ades", {31'b0, ades}, 32'd1);
    checkOutput("sh_mis_adel", {31'b0, adel}, 32'd0);
    step();
    checkOutput("sh_mis_noreq", {31'b0, data_req}, 32'd0);
    memen = 1'b0;
    #1;
    checkOutput("mis_clear", {30'b0, adel, ades}, 32'd0);

    issue("fw", MEMOP_LW, 32'h108, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("fw_req_hold", {31'b0, data_req}, 32'd1);
      step();
    end
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("fw_wait_stall", {31'b0, stall_mem}, 32'd1);
    data_rdata = 32'h11111111; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    checkOutput("fw_readdata", readdata, 32'hDEADBEEF);
    checkIdle("fw");

    issue("fr", MEMOP_LW, 32'h110, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkIdle("fr");

    issue("fa", MEMOP_LW, 32'h114, 32'h0);
    flush = 1'b1; data_addr_ok = 1'b1;
    step();
    flush = 1'b0; data_addr_ok = 1'b0;
    checkOutput("fa_wait_stall", {31'b0, stall_mem}, 32'd1);
    data_rdata = 32'h22222222; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    checkOutput("fa_readdata", readdata, 32'hDEADBEEF);
    checkIdle("fa");

    issue("fd", MEMOP_LW, 32'h10C, 32'h0);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    data_rdata = 32'h0BADF00D; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    checkOutput("fd_readdata", readdata, 32'h0BADF00D);
    pipe_stall = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; pipe_stall = 1'b0;
    checkIdle("fd");

    // reset in WAIT abandons the access; a late data_ok must be ignored
    issue("rw", MEMOP_LW, 32'h118, 32'h0);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("rw_stall", {31'b0, stall_mem}, 32'd0);
    checkOutput("rw_req", {31'b0, data_req}, 32'd0);
    checkOutput("rw_readdata", readdata, 32'd0);
    checkOutput("rw_addr", data_addr, 32'd0);
    checkOutput("rw_wstrb", {28'b0, data_wstrb}, 32'd0);
    step();
    resetn = 1'b1;
    data_rdata = 32'h33333333; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    checkOutput("rw_late_ok", readdata, 32'd0);
    checkOutput("rw_late_stall", {31'b0, stall_mem}, 32'd0);
    checkIdle("rw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
